ledpanel_ctrl_writer: RTL and testbench

//  Producer side of the panel ctrl write bus (ctrl_en/ctrl_addr/ctrl_wdat) consumed by each ledpanel.

---
 rtl/ledpanel_ctrl_writer.sv | 171 +++++++++++++++++
 tb/tb_ledpanel_ctrl_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ledpanel_ctrl_writer.sv
// Packet-to-panel write bridge: header beat selects panel/start address, each pixel beat becomes one ctrl bus write.
// Latency: accepted pixel -> ctrl_en/ctrl_addr/ctrl_wdat registered one cycle later, held for exactly one cycle.
// Backpressure: s_ready low only in reset (and during broadcast replication when CTRL_WRITER_BROADCAST_EN is defined).
module ledpanel_ctrl_writer #(
    parameter int NUM_PANELS  = 8,
    parameter int PIXEL_COUNT = 4096,
    parameter int DATA_WIDTH  = 24
) (
    input  logic                  display_clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_sop,
    input  logic                  s_eop,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [7:0]            ctrl_en,
    output logic [15:0]           ctrl_addr,
    output logic [DATA_WIDTH-1:0] ctrl_wdat,
    output logic [15:0]           pkt_count,
    output logic [15:0]           err_count
);

    localparam logic [7:0]  MAX_PANEL = 8'(NUM_PANELS);
    localparam logic [16:0] ADDR_END  = 17'(PIXEL_COUNT);

`ifdef CTRL_WRITER_BROADCAST_EN
    typedef enum logic [1:0] {IDLE, PIXEL, DROP, BCAST} state_t;
`else
    typedef enum logic [1:0] {IDLE, PIXEL, DROP} state_t;
`endif

    state_t      state_q, state_d;
    logic        ready_q;
    logic [7:0]  panel_q;
    logic [16:0] addr_q;
    logic        acc, hdr_good, addr_full, panel_ok;
    logic        wr_vld, hdr_load, pkt_inc;
    logic [7:0]  wr_panel;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign acc       = s_valid && s_ready;
    assign addr_full = (addr_q >= ADDR_END);
    assign err_sum   = {1'b0, err_count} + {15'd0, err_inc};

`ifdef CTRL_WRITER_BROADCAST_EN
    logic       bcast_q, eop_pend_q, bcast_go;
    logic [7:0] rep_q;

    assign panel_ok = (s_data[23:16] != 8'd0 && s_data[23:16] <= MAX_PANEL) || (s_data[23:16] == 8'hFF);
    assign bcast_go = (state_q == PIXEL) && acc && !s_sop && !addr_full && bcast_q && (MAX_PANEL > 8'd1);
    assign s_ready  = ready_q && (state_q != BCAST);
`else
    assign panel_ok = (s_data[23:16] != 8'd0 && s_data[23:16] <= MAX_PANEL);
    assign s_ready  = ready_q;
`endif

    assign hdr_good = panel_ok && ({1'b0, s_data[15:0]} < ADDR_END);

    always_ff @(posedge display_clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (acc && s_sop) begin
            // any header, even mid-packet, restarts framing
            state_d = s_eop ? IDLE : (hdr_good ? PIXEL : DROP);
        end else if (acc) begin
            case (state_q)
                PIXEL: begin
                    if (addr_full)  state_d = s_eop ? IDLE : DROP;
`ifdef CTRL_WRITER_BROADCAST_EN
                    else if (bcast_go) state_d = BCAST;
`endif
                    else if (s_eop) state_d = IDLE;
                end
                default: state_d = s_eop ? IDLE : DROP;
            endcase
        end
`ifdef CTRL_WRITER_BROADCAST_EN
        if (state_q == BCAST && rep_q == MAX_PANEL) state_d = eop_pend_q ? IDLE : PIXEL;
`endif
    end

    always_comb begin
        wr_vld   = 1'b0;
        wr_panel = 8'd0;
        hdr_load = 1'b0;
        err_inc  = 2'd0;
        pkt_inc  = 1'b0;
        if (acc && s_sop) begin
            hdr_load = hdr_good;
            err_inc  = {1'b0, state_q == PIXEL} + {1'b0, !hdr_good};
            pkt_inc  = hdr_good && s_eop;
        end else if (acc) begin
            case (state_q)
                IDLE: err_inc = 2'd1;
                PIXEL: begin
                    if (addr_full) begin
                        err_inc = 2'd1;
                    end else begin
                        wr_vld   = 1'b1;
                        wr_panel = panel_q;
                        pkt_inc  = s_eop;
`ifdef CTRL_WRITER_BROADCAST_EN
                        if (bcast_q)  wr_panel = 8'd1;
                        if (bcast_go) pkt_inc  = 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
`ifdef CTRL_WRITER_BROADCAST_EN
        if (state_q == BCAST) begin
            wr_vld   = 1'b1;
            wr_panel = rep_q;
            pkt_inc  = (rep_q == MAX_PANEL) && eop_pend_q;
        end
`endif
    end

    always_ff @(posedge display_clock) begin
        if (reset) begin
            ready_q   <= 1'b0;
            ctrl_en   <= 8'd0;
            ctrl_addr <= 16'd0;
            ctrl_wdat <= '0;
            pkt_count <= 16'd0;
            err_count <= 16'd0;
            panel_q   <= 8'd0;
            addr_q    <= 17'd0;
        end else begin
            ready_q <= 1'b1;
            ctrl_en <= wr_vld ? wr_panel : 8'd0;
            // replicas reuse the address/data already on the bus
            if (wr_vld && acc) begin
                ctrl_addr <= addr_q[15:0];
                ctrl_wdat <= s_data;
                addr_q    <= addr_q + 17'd1;
            end
            if (hdr_load) begin
                panel_q <= s_data[23:16];
                addr_q  <= {1'b0, s_data[15:0]};
            end
            if (pkt_inc) pkt_count <= pkt_count + 16'd1;
            err_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

`ifdef CTRL_WRITER_BROADCAST_EN
    always_ff @(posedge display_clock) begin
        if (reset) begin
            bcast_q    <= 1'b0;
            eop_pend_q <= 1'b0;
            rep_q      <= 8'd0;
        end else begin
            if (hdr_load) bcast_q <= (s_data[23:16] == 8'hFF);
            if (bcast_go) begin
                rep_q      <= 8'd2;
                eop_pend_q <= s_eop;
            end else if (state_q == BCAST) begin
                rep_q <= rep_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ledpanel_ctrl_writer.sv
// Directed bench for ledpanel_ctrl_writer: per-scenario tasks with hand-computed expectations.
module tb_ledpanel_ctrl_writer;

    logic        display_clock = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_sop = 1'b0;
    logic        s_eop = 1'b0;
    logic [23:0] s_data = 24'd0;
    logic        s_ready;
    logic [7:0]  ctrl_en;
    logic [15:0] ctrl_addr;
    logic [23:0] ctrl_wdat;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    ledpanel_ctrl_writer #(.NUM_PANELS(8), .PIXEL_COUNT(4096), .DATA_WIDTH(24)) dut (
        .display_clock(display_clock),
        .reset(reset),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_sop(s_sop),
        .s_eop(s_eop),
        .s_data(s_data),
        .ctrl_en(ctrl_en),
        .ctrl_addr(ctrl_addr),
        .ctrl_wdat(ctrl_wdat),
        .pkt_count(pkt_count),
        .err_count(err_count)
    );

    always #5 display_clock = ~display_clock;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int rdy_low = 0;
    logic [7:0]  w_en[$];
    logic [15:0] w_addr[$];
    logic [23:0] w_dat[$];
    int          w_cyc[$];
    int          acc_q[$];

    always @(negedge display_clock) begin
        if (ctrl_en != 8'd0) begin
            w_en.push_back(ctrl_en);
            w_addr.push_back(ctrl_addr);
            w_dat.push_back(ctrl_wdat);
            w_cyc.push_back(cyc);
        end
        if (!reset && !s_ready) rdy_low++;
        cyc++;
    end

    task automatic clear_log();
        w_en.delete(); w_addr.delete(); w_dat.delete(); w_cyc.delete(); acc_q.delete();
        rdy_low = 0;
    endtask

    task automatic beat(input logic sop, input logic eop, input logic [23:0] d);
        int n = 0;
        @(negedge display_clock);
        s_valid = 1'b1; s_sop = sop; s_eop = eop; s_data = d;
        while (!s_ready && n < 50) begin
            @(negedge display_clock);
            n++;
        end
        if (n >= 50) begin
            compared++; mismatched++;
            $display("FAIL beat_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
        end
        @(posedge display_clock);
        #1;
        acc_q.push_back(cyc);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge display_clock);
        reset = 1'b1; s_valid = 1'b0;
        repeat (2) @(negedge display_clock);
        reset = 1'b0;
        @(negedge display_clock);
        clear_log();
    endtask

    task automatic test_reset();
        @(negedge display_clock);
        reset = 1'b1; s_valid = 1'b0;
        repeat (2) @(negedge display_clock);
        compared += 6;
        if (ctrl_en !== 8'd0)    begin mismatched++; $display("FAIL rst_ctrl_en: got %0h want 0", ctrl_en); end
        if (ctrl_addr !== 16'd0) begin mismatched++; $display("FAIL rst_ctrl_addr: got %0h want 0", ctrl_addr); end
        if (ctrl_wdat !== 24'd0) begin mismatched++; $display("FAIL rst_ctrl_wdat: got %0h want 0", ctrl_wdat); end
        if (pkt_count !== 16'd0) begin mismatched++; $display("FAIL rst_pkt: got %0d want 0", pkt_count); end
        if (err_count !== 16'd0) begin mismatched++; $display("FAIL rst_err: got %0d want 0", err_count); end
        if (s_ready !== 1'b0)    begin mismatched++; $display("FAIL rst_ready: got %0b want 0", s_ready); end
        reset = 1'b0;
        @(negedge display_clock);
        compared++;
        if (s_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_rst: got %0b want 1", s_ready); end
    endtask

    task automatic test_stream();
        logic [23:0] ed [3];
        ed = '{24'h112233, 24'h445566, 24'h778899};
        do_reset();
        beat(1'b1, 1'b0, {8'd2, 16'd0});
        beat(1'b0, 1'b0, ed[0]);
        beat(1'b0, 1'b0, ed[1]);
        beat(1'b0, 1'b1, ed[2]);
        repeat (3) @(negedge display_clock);
        compared++;
        if (w_en.size() != 3) begin mismatched++; $display("FAIL stream_nwrites: got %0d want 3", w_en.size()); end
        for (int i = 0; i < 3 && i < w_en.size(); i++) begin
            compared += 4;
            if (w_en[i] !== 8'd2) begin mismatched++; $display("FAIL stream_en[%0d]: got %0d want 2", i, w_en[i]); end
            if (w_addr[i] !== 16'(i)) begin mismatched++; $display("FAIL stream_addr[%0d]: got %0d want %0d", i, w_addr[i], i); end
            if (w_dat[i] !== ed[i]) begin mismatched++; $display("FAIL stream_dat[%0d]: got %h want %h", i, w_dat[i], ed[i]); end
            if (w_cyc[i] != acc_q[i+1]) begin mismatched++; $display("FAIL stream_latency[%0d]: write cyc %0d want %0d", i, w_cyc[i], acc_q[i+1]); end
        end
        compared += 2;
        if (pkt_count !== 16'd1) begin mismatched++; $display("FAIL stream_pkt: got %0d want 1", pkt_count); end
        if (err_count !== 16'd0) begin mismatched++; $display("FAIL stream_err: got %0d want 0", err_count); end
    endtask

    task automatic test_bad_panel();
        do_reset();
        beat(1'b1, 1'b0, {8'd0, 16'd0});
        beat(1'b0, 1'b0, 24'h010203);
        beat(1'b0, 1'b1, 24'h040506);
        repeat (3) @(negedge display_clock);
        compared += 4;
        if (w_en.size() != 0)    begin mismatched++; $display("FAIL badpanel_writes: got %0d want 0", w_en.size()); end
        if (err_count !== 16'd1) begin mismatched++; $display("FAIL badpanel_err: got %0d want 1", err_count); end
        if (pkt_count !== 16'd0) begin mismatched++; $display("FAIL badpanel_pkt: got %0d want 0", pkt_count); end
        if (rdy_low != 0)        begin mismatched++; $display("FAIL badpanel_ready: low %0d cycles want 0", rdy_low); end
    endtask

    task automatic test_addr_overflow();
        do_reset();
        beat(1'b1, 1'b0, {8'd1, 16'd4094});
        beat(1'b0, 1'b0, 24'hA00001);
        beat(1'b0, 1'b0, 24'hA00002);
        beat(1'b0, 1'b0, 24'hA00003);
        beat(1'b0, 1'b1, 24'hA00004);
        repeat (3) @(negedge display_clock);
        compared += 3;
        if (w_en.size() != 2)    begin mismatched++; $display("FAIL ovf_nwrites: got %0d want 2", w_en.size()); end
        if (err_count !== 16'd1) begin mismatched++; $display("FAIL ovf_err: got %0d want 1", err_count); end
        if (pkt_count !== 16'd0) begin mismatched++; $display("FAIL ovf_pkt: got %0d want 0", pkt_count); end
        if (w_en.size() >= 2) begin
            compared += 4;
            if (w_addr[0] !== 16'd4094) begin mismatched++; $display("FAIL ovf_addr0: got %0d want 4094", w_addr[0]); end
            if (w_addr[1] !== 16'd4095) begin mismatched++; $display("FAIL ovf_addr1: got %0d want 4095", w_addr[1]); end
            if (w_dat[1] !== 24'hA00002) begin mismatched++; $display("FAIL ovf_dat1: got %h want a00002", w_dat[1]); end
            if (w_en[1] !== 8'd1) begin mismatched++; $display("FAIL ovf_en1: got %0d want 1", w_en[1]); end
        end
    endtask

    task automatic test_sop_in_pixel();
        do_reset();
        beat(1'b1, 1'b0, {8'd3, 16'd10});
        beat(1'b0, 1'b0, 24'h000001);
        beat(1'b1, 1'b0, {8'd4, 16'd20});
        beat(1'b0, 1'b1, 24'h000002);
        repeat (3) @(negedge display_clock);
        compared += 3;
        if (w_en.size() != 2)    begin mismatched++; $display("FAIL resync_nwrites: got %0d want 2", w_en.size()); end
        if (err_count !== 16'd1) begin mismatched++; $display("FAIL resync_err: got %0d want 1", err_count); end
        if (pkt_count !== 16'd1) begin mismatched++; $display("FAIL resync_pkt: got %0d want 1", pkt_count); end
        if (w_en.size() >= 2) begin
            compared += 4;
            if (w_en[0] !== 8'd3)    begin mismatched++; $display("FAIL resync_en0: got %0d want 3", w_en[0]); end
            if (w_addr[0] !== 16'd10) begin mismatched++; $display("FAIL resync_addr0: got %0d want 10", w_addr[0]); end
            if (w_en[1] !== 8'd4)    begin mismatched++; $display("FAIL resync_en1: got %0d want 4", w_en[1]); end
            if (w_addr[1] !== 16'd20) begin mismatched++; $display("FAIL resync_addr1: got %0d want 20", w_addr[1]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        beat(1'b1, 1'b1, {8'd5, 16'd7});
        beat(1'b1, 1'b1, {8'd5, 16'd8});
        beat(1'b1, 1'b0, {8'd6, 16'd100});
        beat(1'b0, 1'b1, 24'hC0FFEE);
        repeat (3) @(negedge display_clock);
        compared += 3;
        if (pkt_count !== 16'd3) begin mismatched++; $display("FAIL b2b_pkt: got %0d want 3", pkt_count); end
        if (err_count !== 16'd0) begin mismatched++; $display("FAIL b2b_err: got %0d want 0", err_count); end
        if (w_en.size() != 1)    begin mismatched++; $display("FAIL b2b_nwrites: got %0d want 1", w_en.size()); end
        if (w_en.size() >= 1) begin
            compared += 3;
            if (w_en[0] !== 8'd6)      begin mismatched++; $display("FAIL b2b_en: got %0d want 6", w_en[0]); end
            if (w_addr[0] !== 16'd100) begin mismatched++; $display("FAIL b2b_addr: got %0d want 100", w_addr[0]); end
            if (w_dat[0] !== 24'hC0FFEE) begin mismatched++; $display("FAIL b2b_dat: got %h want c0ffee", w_dat[0]); end
        end
    endtask

    task automatic test_broadcast();
        do_reset();
        beat(1'b1, 1'b0, {8'hFF, 16'd5});
        beat(1'b0, 1'b1, 24'hABCDEF);
        repeat (12) @(negedge display_clock);
`ifdef CTRL_WRITER_BROADCAST_EN
        compared += 3;
        if (w_en.size() != 8)    begin mismatched++; $display("FAIL bcast_nwrites: got %0d want 8", w_en.size()); end
        if (pkt_count !== 16'd1) begin mismatched++; $display("FAIL bcast_pkt: got %0d want 1", pkt_count); end
        if (rdy_low != 7)        begin mismatched++; $display("FAIL bcast_ready_low: got %0d want 7", rdy_low); end
        for (int i = 0; i < w_en.size() && i < 8; i++) begin
            compared += 4;
            if (w_en[i] !== 8'(i + 1)) begin mismatched++; $display("FAIL bcast_en[%0d]: got %0d want %0d", i, w_en[i], i + 1); end
            if (w_addr[i] !== 16'd5)   begin mismatched++; $display("FAIL bcast_addr[%0d]: got %0d want 5", i, w_addr[i]); end
            if (w_dat[i] !== 24'hABCDEF) begin mismatched++; $display("FAIL bcast_dat[%0d]: got %h want abcdef", i, w_dat[i]); end
            if (w_cyc[i] != acc_q[1] + i) begin mismatched++; $display("FAIL bcast_cyc[%0d]: got %0d want %0d", i, w_cyc[i], acc_q[1] + i); end
        end
`else
        compared += 4;
        if (w_en.size() != 0)    begin mismatched++; $display("FAIL ff_panel_writes: got %0d want 0", w_en.size()); end
        if (err_count !== 16'd1) begin mismatched++; $display("FAIL ff_panel_err: got %0d want 1", err_count); end
        if (pkt_count !== 16'd0) begin mismatched++; $display("FAIL ff_panel_pkt: got %0d want 0", pkt_count); end
        if (rdy_low != 0)        begin mismatched++; $display("FAIL ff_panel_ready: low %0d cycles want 0", rdy_low); end
`endif
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        beat(1'b0, 1'b1, 24'h000055);
        beat(1'b1, 1'b1, {8'd7, 16'd3});
        beat(1'b1, 1'b0, {8'd2, 16'd0});
        beat(1'b0, 1'b0, 24'h111111);
        beat(1'b0, 1'b0, 24'h222222);
        compared += 2;
        if (err_count !== 16'd1) begin mismatched++; $display("FAIL prerst_err: got %0d want 1", err_count); end
        if (pkt_count !== 16'd1) begin mismatched++; $display("FAIL prerst_pkt: got %0d want 1", pkt_count); end
        @(negedge display_clock);
        s_valid = 1'b1; s_sop = 1'b0; s_eop = 1'b0; s_data = 24'h333333;
        reset = 1'b1;
        @(negedge display_clock);
        compared += 4;
        if (ctrl_en !== 8'd0)    begin mismatched++; $display("FAIL midrst_en: got %0d want 0", ctrl_en); end
        if (pkt_count !== 16'd0) begin mismatched++; $display("FAIL midrst_pkt: got %0d want 0", pkt_count); end
        if (err_count !== 16'd0) begin mismatched++; $display("FAIL midrst_err: got %0d want 0", err_count); end
        if (ctrl_addr !== 16'd0) begin mismatched++; $display("FAIL midrst_addr: got %0d want 0", ctrl_addr); end
        s_valid = 1'b0;
        reset = 1'b0;
        @(negedge display_clock);
        clear_log();
        beat(1'b0, 1'b1, 24'h0000AA);
        repeat (3) @(negedge display_clock);
        compared += 3;
        if (err_count !== 16'd1) begin mismatched++; $display("FAIL postrst_err: got %0d want 1", err_count); end
        if (w_en.size() != 0)    begin mismatched++; $display("FAIL postrst_writes: got %0d want 0", w_en.size()); end
        if (pkt_count !== 16'd0) begin mismatched++; $display("FAIL postrst_pkt: got %0d want 0", pkt_count); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_bad_panel();
        test_addr_overflow();
        test_sop_in_pixel();
        test_back_to_back();
        test_broadcast();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
